// File: rtl/shift_ex_stage.sv
// shift_ex_stage
//   Two-register EX-stage slice around an external 32-bit combinational left
//   shifter. Stage 1 latches a decoded shift instruction from ID/EX with its
//   operands already resolved through forwarding. Stage 2 holds the shifted
//   result for EX/MEM. Right shifts use the same left shifter: the operand
//   and the result are both bit-reversed around it.
//
//   Ports
//     clk, rst           clock, synchronous active-high reset
//     flush              synchronous pipeline flush (drops both stages)
//     in_valid/in_ready  ID/EX handshake
//     in_op              00 SLL, 01 SRL, 10 SLLV, 11 SRLV
//     in_rt_data         value to shift (before forwarding)
//     in_rs_data         variable shift amount source (before forwarding)
//     in_shamt, in_rd    immediate shift amount, destination register
//     fwd_sel_rt/_rs     00 regfile, 01 EX/MEM, 10 MEM/WB, 11 regfile
//     exmem_data         forwarded value from EX/MEM
//     memwb_data         forwarded value from MEM/WB
//     sh_dataA/B         shifter data and amount inputs
//     sh_dataOut         shifter output (combinational)
//     out_valid/out_ready EX/MEM handshake
//     out_result, out_rd shifted value and its destination register
module shift_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_rt_data,
   input  logic [31:0] in_rs_data,
   input  logic [4:0]  in_shamt,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  fwd_sel_rt,
   input  logic [1:0]  fwd_sel_rs,
   input  logic [31:0] exmem_data,
   input  logic [31:0] memwb_data,
   output logic [31:0] sh_dataA,
   output logic [4:0]  sh_dataB,
   input  logic [31:0] sh_dataOut,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd
);

   // Stage 1 state
   logic        s1_valid;
   logic [1:0]  s1_op;
   logic [31:0] s1_rt;
   logic [4:0]  s1_amt;
   logic [4:0]  s1_rd;

   logic        s2_free;
   logic        s1_adv;
   logic        s1_load;
   logic [31:0] rt_f;
   logic [31:0] rs_f;
   logic [4:0]  amt_sel;
   logic [31:0] result;

   function automatic logic [31:0] bitrev(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] rf,
                                           input logic [31:0] exm,
                                           input logic [31:0] mwb);
      logic [31:0] r;
      case (sel)
         2'b01:   r = exm;
         2'b10:   r = mwb;
         default: r = rf;
      endcase
      return r;
   endfunction

   // Handshake and operand resolution
   always_comb begin
      s2_free  = ~out_valid | out_ready;
      s1_adv   = s1_valid & s2_free;
      in_ready = ~s1_valid | s1_adv;
      s1_load  = in_valid & in_ready;

      rt_f     = fwd_mux(fwd_sel_rt, in_rt_data, exmem_data, memwb_data);
      rs_f     = fwd_mux(fwd_sel_rs, in_rs_data, exmem_data, memwb_data);
      // op[1] selects the variable (register) amount; only rs[4:0] matters
      amt_sel  = in_op[1] ? rs_f[4:0] : in_shamt;
   end

   // Shifter drive and result un-reversal, from stage 1 only. op[0] marks a
   // right shift: reverse in, shift left, reverse out.
   always_comb begin
      sh_dataB = s1_amt;
      sh_dataA = s1_op[0] ? bitrev(s1_rt) : s1_rt;
      result   = s1_op[0] ? bitrev(sh_dataOut) : sh_dataOut;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_op      <= '0;
         s1_rt      <= '0;
         s1_amt     <= '0;
         s1_rd      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
      end else if (flush) begin
         // Data registers keep stale contents; only occupancy is dropped.
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_rt    <= rt_f;
            s1_amt   <= amt_sel;
            s1_rd    <= in_rd;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s1_adv) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_rd     <= s1_rd;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_ex_stage.sv
// tb_shift_ex_stage
//   Scoreboarded bench for shift_ex_stage. A behavioural left shifter closes
//   the loop on sh_dataA/sh_dataB. Expected results are computed from the
//   driven inputs with native << / >> and queued at each input handshake;
//   they are popped and compared at each output handshake.
module tb_shift_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rt_data;
   logic [31:0] in_rs_data;
   logic [4:0]  in_shamt;
   logic [4:0]  in_rd;
   logic [1:0]  fwd_sel_rt;
   logic [1:0]  fwd_sel_rs;
   logic [31:0] exmem_data;
   logic [31:0] memwb_data;
   logic [31:0] sh_dataA;
   logic [4:0]  sh_dataB;
   logic [31:0] sh_dataOut;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   always #5 clk = ~clk;

   assign sh_dataOut = sh_dataA << sh_dataB;

   shift_ex_stage dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rt_data (in_rt_data),
      .in_rs_data (in_rs_data),
      .in_shamt   (in_shamt),
      .in_rd      (in_rd),
      .fwd_sel_rt (fwd_sel_rt),
      .fwd_sel_rs (fwd_sel_rs),
      .exmem_data (exmem_data),
      .memwb_data (memwb_data),
      .sh_dataA   (sh_dataA),
      .sh_dataB   (sh_dataB),
      .sh_dataOut (sh_dataOut),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd)
   );

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   bit          rand_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] exm, input logic [31:0] mwb);
      if (sel == 2'b01) return exm;
      if (sel == 2'b10) return mwb;
      return rf;
   endfunction

   function automatic exp_t model();
      exp_t        e;
      logic [31:0] rt;
      logic [31:0] rs;
      logic [4:0]  amt;
      rt    = fwd(fwd_sel_rt, in_rt_data, exmem_data, memwb_data);
      rs    = fwd(fwd_sel_rs, in_rs_data, exmem_data, memwb_data);
      amt   = (in_op == 2'b10 || in_op == 2'b11) ? rs[4:0] : in_shamt;
      e.res = (in_op == 2'b01 || in_op == 2'b11) ? (rt >> amt) : (rt << amt);
      e.rd  = in_rd;
      return e;
   endfunction

   // Inputs change just after posedge; the negedge sees what the next edge will.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_out got=%h exp=none", out_result);
            end else begin
               mon_e = sb.pop_front();
               check("sb_result", out_result, mon_e.res);
               check("sb_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
            end
         end
         if (in_valid && in_ready) sb.push_back(model());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] rt, input logic [31:0] rs,
                       input logic [4:0] sh, input logic [4:0] rd,
                       input logic [1:0] frt, input logic [1:0] frs,
                       input logic [31:0] exm, input logic [31:0] mwb);
      int n;
      in_op = op; in_rt_data = rt; in_rs_data = rs; in_shamt = sh; in_rd = rd;
      fwd_sel_rt = frt; fwd_sel_rs = frs; exmem_data = exm; memwb_data = mwb;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
      in_rt_data = '0; in_rs_data = '0; in_shamt = '0; in_rd = '0;
      fwd_sel_rt = '0; fwd_sel_rs = '0; exmem_data = '0; memwb_data = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'h0);
      check("rst_out_rd", {27'd0, out_rd}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_sh_dataA", sh_dataA, 32'h0);
      check("rst_sh_dataB", {27'd0, sh_dataB}, 32'd0);
      rst = 1'b0;
      tick();

      // SLL 1 by 31: latency and direct result
      in_op = 2'b00; in_rt_data = 32'h1; in_shamt = 5'd31; in_rd = 5'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat_s1_only", {31'd0, out_valid}, 32'd0);
      check("sll_dataA", sh_dataA, 32'h1);
      check("sll_dataB", {27'd0, sh_dataB}, 32'd31);
      tick();
      check("lat_out_valid", {31'd0, out_valid}, 32'd1);
      check("sll31_result", out_result, 32'h8000_0000);
      check("sll31_rd", {27'd0, out_rd}, 32'd5);

      // SRL: shifter sees the reversed operand
      in_op = 2'b01; in_rt_data = 32'h8000_0000; in_shamt = 5'd4; in_rd = 5'd6; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("srl_dataA_rev", sh_dataA, 32'h1);
      check("srl_dataB", {27'd0, sh_dataB}, 32'd4);
      tick();
      check("srl4_result", out_result, 32'h0800_0000);

      send(2'b01, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd7, 2'b00, 2'b00, 32'h0, 32'h0);
      send(2'b10, 32'h0000_000F, 32'hFFFF_FFE3, 5'd17, 5'd8, 2'b00, 2'b00, 32'h0, 32'h0);
      send(2'b11, 32'h1234_5678, 32'd28, 5'd0, 5'd9, 2'b01, 2'b00, 32'hF000_0000, 32'h0);
      send(2'b10, 32'h0000_0003, 32'h0, 5'd0, 5'd10, 2'b00, 2'b10, 32'h0, 32'hFFFF_FFE5);
      send(2'b00, 32'hA5A5_A5A5, 32'h0, 5'd8, 5'd11, 2'b11, 2'b11, 32'h1111_1111, 32'h2222_2222);
      send(2'b11, 32'hFFFF_FFFF, 32'h0, 5'd9, 5'd12, 2'b10, 2'b01, 32'h0000_001F, 32'h8000_0001);
      tick(); tick(); tick();
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back with a three-cycle output stall
      out_ready = 1'b0;
      fork
         begin
            for (int k = 1; k <= 4; k++)
               send(2'b00, 32'h1, 32'h0, k[4:0], k[4:0], 2'b00, 2'b00, 32'h0, 32'h0);
         end
         begin
            tick(); tick(); tick();
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_result", out_result, 32'h2);
            check("stall_hold_dataB", {27'd0, sh_dataB}, 32'd2);
            out_ready = 1'b1;
            tick();
            check("b2b_2nd", out_result, 32'h4);
            tick();
            check("b2b_3rd", out_result, 32'h8);
            tick();
            check("b2b_4th", out_result, 32'h10);
         end
      join
      tick(); tick();

      // Flush with both stages full and a third instruction offered
      out_ready = 1'b0;
      send(2'b00, 32'h1, 32'h0, 5'd1, 5'd1, 2'b00, 2'b00, 32'h0, 32'h0);
      send(2'b00, 32'h1, 32'h0, 5'd2, 5'd2, 2'b00, 2'b00, 32'h0, 32'h0);
      in_op = 2'b00; in_rt_data = 32'h1; in_shamt = 5'd3; in_rd = 5'd3; in_valid = 1'b1;
      flush = 1'b1;
      tick();
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("flush_no_capture", {31'd0, out_valid}, 32'd0);
      check("flush_s1_empty", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();

      // Reset during a full stall
      out_ready = 1'b0;
      send(2'b00, 32'h3, 32'h0, 5'd4, 5'd13, 2'b00, 2'b00, 32'h0, 32'h0);
      send(2'b01, 32'h300, 32'h0, 5'd4, 5'd14, 2'b00, 2'b00, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      check("rst_stall_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_stall_result", out_result, 32'h0);
      check("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      check("rst_stall_empty", {31'd0, out_valid}, 32'd0);

      // Random traffic under random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 60; k++)
               send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom, $urandom);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      out_ready = 1'b1;
      repeat (4) tick();
      check("drain_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Two-register EX-stage pipeline slice that feeds the 32-bit combinational left shifter and captures its result.
- Latches decoded shift instructions from ID/EX and resolves operand forwarding at capture.
- Drives the shifter's data and amount inputs from registered operands; bit-reverses around the shifter so it also performs logical right shifts.
- Registers the shifted result with valid/ready handshakes toward EX/MEM.

Parameters:
- none (datapath fixed at 32 bits, shift amount fixed at 5 bits)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush (branch/exception)
- in_valid  in  1  ID/EX holds a shift instruction
- in_ready  out  1  stage-1 register can accept this cycle
- in_op  in  2  00 SLL, 01 SRL, 10 SLLV, 11 SRLV
- in_rt_data  in  32  value to shift (pre-forwarding)
- in_rs_data  in  32  variable shift amount source (pre-forwarding)
- in_shamt  in  5  immediate shift amount
- in_rd  in  5  destination register number
- fwd_sel_rt  in  2  00 register file, 01 EX/MEM, 10 MEM/WB, 11 treated as 00
- fwd_sel_rs  in  2  same encoding as fwd_sel_rt
- exmem_data  in  32  forwarded value from EX/MEM
- memwb_data  in  32  forwarded value from MEM/WB
- sh_dataA  out  32  to shifter data input
- sh_dataB  out  5  to shifter amount input
- sh_dataOut  in  32  from shifter output (combinational)
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  EX/MEM accepts result
- out_result  out  32  shifted value
- out_rd  out  5  destination register, travels with out_result

Behaviour:
- Registers:
  - Stage 1 (S1): s1_valid, s1_op, s1_rt, s1_amt, s1_rd.
  - Stage 2 (S2): out_valid, out_result, out_rd.
- Reset (rst=1 at edge):
  - s1_valid=0 and out_valid=0.
  - out_result=0x00000000, out_rd=0, s1_rt=0, s1_amt=0, s1_op=00.
  - in_ready=1 in the cycle after reset.
- Operand selection at capture:
  - rt_f = forwarding mux of in_rt_data per fwd_sel_rt; rs_f = same for rs per fwd_sel_rs.
  - s1_amt = in_shamt for SLL/SRL; rs_f[4:0] for SLLV/SRLV. rs_f[31:5] is ignored.
- Shifter drive (combinational from S1 only):
  - sh_dataB = s1_amt.
  - sh_dataA = s1_rt for left ops; bit-reverse(s1_rt) for right ops (bit i gets bit 31-i).
  - Result mux: sh_dataOut for left ops; bit-reverse(sh_dataOut) for right ops.
- Handshake:
  - s2_free = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = ~s1_valid | s1_adv (combinational).
  - S1 captures when in_valid & in_ready.
  - S2 captures the result mux, s1_rd and sets out_valid when s1_adv.
  - out_valid clears when out_ready & ~s1_adv.
  - Simultaneous S1 capture and s1_adv in one cycle sustains 1 instruction/cycle.
- Latency and ordering:
  - in handshake at edge N → out_valid=1 after edge N+1 when unstalled.
  - Strict in-order delivery; no drops or duplicates under any out_ready pattern.
- Stall: with out_ready=0 and both stages full, all registers and sh_dataA/B hold, in_ready=0, and out_result stays stable.
- Flush:
  - At edge: s1_valid=0 and out_valid=0; data registers may keep stale values.
  - An in_valid in the flush cycle is not captured.
  - Flush dominates capture and advance; rst dominates flush.
- Shift amount 0 → out_result = rt_f unchanged for all ops; amount 31 is legal.
- Reset mid-stall: both valids drop at the reset edge and the pending results are discarded.

Test Plan:
- SLL, rt=0x00000001, shamt=31, fwd 00 → out_valid one cycle after capture, out_result=0x80000000, out_rd as sent.
- SRL, rt=0x80000000, shamt=4 → 0x08000000; SRL shamt=0, rt=0xDEADBEEF → 0xDEADBEEF.
- SLLV, rs=0xFFFFFFE3, rt=0x0000000F → 0x00000078; SRLV with fwd_sel_rt=01, exmem_data=0xF0000000, rs amount 28 → 0x0000000F (forwarded value used).
- Back-to-back 4 SLLs (amounts 1,2,3,4 of 0x1) with out_ready held low 3 cycles → in_ready=0 after 2 captured; outputs 0x2,0x4,0x8,0x10 in order, one per cycle once out_ready=1.
- Flush asserted while both stages full and in_valid=1 → next cycle out_valid=0, s1 empty, in_ready=1; that third instruction never appears.
- rst asserted during stall with both stages valid → next cycle out_valid=0, out_result=0x00000000, in_ready=1.
